// File: rtl/risc_pkg.sv
// Shared definitions for the 16-bit RISC core: control-word bit positions,
// ALU op encodings and datapath widths.
package risc_pkg;

  localparam int unsigned REG_ADDR_BITS = 3;
  localparam int unsigned REG_SIZE      = 16;
  localparam int unsigned PC_SIZE       = 16;
  localparam int unsigned CTRL_W        = 9;
  localparam int unsigned ALUOP_W       = 2;
  localparam int unsigned IMM_W         = 6;
  localparam int unsigned FUNCT_W       = 3;

  // Control word bit indices, MSB to LSB
  localparam int unsigned CTRL_BNE       = 8;
  localparam int unsigned CTRL_WE        = 7;
  localparam int unsigned CTRL_MEM_TO_REG = 6;
  localparam int unsigned CTRL_REG_DST   = 5;
  localparam int unsigned CTRL_ALU_SRC   = 4;
  localparam int unsigned CTRL_MEM_WRITE = 3;
  localparam int unsigned CTRL_MEM_READ  = 2;
  localparam int unsigned CTRL_BEQ       = 1;
  localparam int unsigned CTRL_JUMP      = 0;

  typedef enum logic [ALUOP_W-1:0] {
    ALUOP_RTYPE = 2'b00,
    ALUOP_BR    = 2'b01,
    ALUOP_MEM   = 2'b10
  } alu_op_e;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detector: flags an ID instruction that reads the register
// a load currently in EX is about to write.
module load_use_detect #(
  parameter int unsigned REG_ADDR_BITS = risc_pkg::REG_ADDR_BITS
) (
  input  logic                     id_valid,
  input  logic                     id_jump,
  input  logic                     id_mem_read,
  input  logic [REG_ADDR_BITS-1:0] id_rs,
  input  logic [REG_ADDR_BITS-1:0] id_rt,
  input  logic                     ex_valid,
  input  logic                     ex_mem_read,
  input  logic [REG_ADDR_BITS-1:0] ex_rt,
  output logic                     hazard_c
);

  logic uses_rs;
  logic uses_rt;

  // A load writes its rt, so rt is only a source for non-load, non-jump ops
  assign uses_rs = !id_jump;
  assign uses_rt = !id_jump && !id_mem_read;

  assign hazard_c = id_valid && ex_valid && ex_mem_read &&
                    ((uses_rs && (id_rs == ex_rt)) || (uses_rt && (id_rt == ex_rt)));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, branch/jump squash and
// saturating stall/flush event counters.
module id_ex_stage #(
  parameter int unsigned REG_ADDR_BITS = risc_pkg::REG_ADDR_BITS,
  parameter int unsigned REG_SIZE      = risc_pkg::REG_SIZE,
  parameter int unsigned PC_SIZE       = risc_pkg::PC_SIZE,
  parameter int unsigned CNT_W         = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     id_valid,
  input  logic [PC_SIZE-1:0]       id_pc,
  input  logic [8:0]               id_ctrl,
  input  logic [1:0]               id_alu_op,
  input  logic [REG_ADDR_BITS-1:0] id_rs,
  input  logic [REG_ADDR_BITS-1:0] id_rt,
  input  logic [REG_ADDR_BITS-1:0] id_rd,
  input  logic [REG_SIZE-1:0]      id_rs_data,
  input  logic [REG_SIZE-1:0]      id_rt_data,
  input  logic [5:0]               id_imm,
  input  logic [2:0]               id_funct,
  input  logic                     flush,
  output logic                     stall,
  output logic                     ex_valid,
  output logic [8:0]               ex_ctrl,
  output logic [1:0]               ex_alu_op,
  output logic [PC_SIZE-1:0]       ex_pc,
  output logic [REG_ADDR_BITS-1:0] ex_rs,
  output logic [REG_ADDR_BITS-1:0] ex_rt,
  output logic [REG_ADDR_BITS-1:0] ex_rd,
  output logic [REG_SIZE-1:0]      ex_rs_data,
  output logic [REG_SIZE-1:0]      ex_rt_data,
  output logic [REG_SIZE-1:0]      ex_imm,
  output logic [2:0]               ex_funct,
  output logic [CNT_W-1:0]         stall_cnt,
  output logic [CNT_W-1:0]         flush_cnt
);

  import risc_pkg::*;

  logic hazard;
  logic load;

  load_use_detect #(
    .REG_ADDR_BITS(REG_ADDR_BITS)
  ) u_load_use_detect (
    .id_valid   (id_valid),
    .id_jump    (id_ctrl[CTRL_JUMP]),
    .id_mem_read(id_ctrl[CTRL_MEM_READ]),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .ex_valid   (ex_valid),
    .ex_mem_read(ex_ctrl[CTRL_MEM_READ]),
    .ex_rt      (ex_rt),
    .hazard_c   (hazard)
  );

  // Flush outranks the hazard: the stalled instruction is being squashed anyway
  assign stall = hazard && !flush;
  assign load  = !flush && !hazard && id_valid;

  // Datapath fields load every cycle; only valid/ctrl distinguish a bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid   <= 1'b0;
      ex_ctrl    <= '0;
      ex_alu_op  <= '0;
      ex_pc      <= '0;
      ex_rs      <= '0;
      ex_rt      <= '0;
      ex_rd      <= '0;
      ex_rs_data <= '0;
      ex_rt_data <= '0;
      ex_imm     <= '0;
      ex_funct   <= '0;
    end else begin
      ex_valid   <= load;
      ex_ctrl    <= load ? id_ctrl : 9'(0);
      ex_alu_op  <= id_alu_op;
      ex_pc      <= id_pc;
      ex_rs      <= id_rs;
      ex_rt      <= id_rt;
      ex_rd      <= id_rd;
      ex_rs_data <= id_rs_data;
      ex_rt_data <= id_rt_data;
      ex_imm     <= {{(REG_SIZE-IMM_W){id_imm[IMM_W-1]}}, id_imm};
      ex_funct   <= id_funct;
    end
  end

  // Saturating event counters
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (flush && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
      if (stall && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: the driver queues expected per-cycle
// observations, a negedge monitor pops and compares them.
module tb_id_ex_stage;

  localparam logic [8:0] ADD = 9'h0A0;
  localparam logic [8:0] LW  = 9'h0D4;
  localparam logic [8:0] J   = 9'h001;

  typedef struct {
    logic        stall;
    logic        valid;
    logic [8:0]  ctrl;
    logic [15:0] imm;
    logic [2:0]  rd;
    logic [3:0]  sc;
    logic [3:0]  fc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [15:0] id_pc;
  logic [8:0]  id_ctrl;
  logic [1:0]  id_alu_op;
  logic [2:0]  id_rs, id_rt, id_rd;
  logic [15:0] id_rs_data, id_rt_data;
  logic [5:0]  id_imm;
  logic [2:0]  id_funct;
  logic        flush;
  logic        stall;
  logic        ex_valid;
  logic [8:0]  ex_ctrl;
  logic [1:0]  ex_alu_op;
  logic [15:0] ex_pc;
  logic [2:0]  ex_rs, ex_rt, ex_rd;
  logic [15:0] ex_rs_data, ex_rt_data, ex_imm;
  logic [2:0]  ex_funct;
  logic [3:0]  stall_cnt, flush_cnt;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  id_ex_stage #(
    .REG_ADDR_BITS(3), .REG_SIZE(16), .PC_SIZE(16), .CNT_W(4)
  ) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc), .id_ctrl(id_ctrl),
    .id_alu_op(id_alu_op), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_funct(id_funct), .flush(flush), .stall(stall), .ex_valid(ex_valid),
    .ex_ctrl(ex_ctrl), .ex_alu_op(ex_alu_op), .ex_pc(ex_pc), .ex_rs(ex_rs),
    .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
    .ex_imm(ex_imm), .ex_funct(ex_funct), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Monitor: stall reflects the held ID inputs; ex_* reflect the previous edge
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("stall",     16'(stall),     16'(e.stall));
      chk("ex_valid",  16'(ex_valid),  16'(e.valid));
      chk("ex_ctrl",   16'(ex_ctrl),   16'(e.ctrl));
      chk("stall_cnt", 16'(stall_cnt), 16'(e.sc));
      chk("flush_cnt", 16'(flush_cnt), 16'(e.fc));
      if (e.valid) begin
        chk("ex_imm", ex_imm,        e.imm);
        chk("ex_rd",  16'(ex_rd),    16'(e.rd));
      end
    end
  end

  function automatic exp_t mk(input logic s, input logic v, input logic [8:0] c,
                              input logic [15:0] im, input logic [2:0] rd,
                              input logic [3:0] sc, input logic [3:0] fc);
    exp_t e;
    e.stall = s; e.valid = v; e.ctrl = c; e.imm = im; e.rd = rd; e.sc = sc; e.fc = fc;
    return e;
  endfunction

  task automatic vec(input logic r, input logic v, input logic [8:0] c,
                     input logic [2:0] rs_, input logic [2:0] rt_, input logic [2:0] rd_,
                     input logic [5:0] im, input logic f, input exp_t e);
    @(posedge clk);
    #1;
    rst        = r;
    id_valid   = v;
    id_ctrl    = c;
    id_alu_op  = (c == LW) ? 2'b10 : 2'b00;
    id_rs      = rs_;
    id_rt      = rt_;
    id_rd      = rd_;
    id_rs_data = 16'h1000 + 16'(rs_);
    id_rt_data = 16'h2000 + 16'(rt_);
    id_imm     = im;
    id_funct   = 3'd0;
    id_pc      = id_pc + 16'd2;
    flush      = f;
    q.push_back(e);
  endtask

  initial begin
    int sat;
    rst = 1'b1; id_valid = 1'b0; id_pc = '0; id_ctrl = '0; id_alu_op = '0;
    id_rs = '0; id_rt = '0; id_rd = '0; id_rs_data = '0; id_rt_data = '0;
    id_imm = '0; id_funct = '0; flush = 1'b0;
    repeat (2) @(posedge clk);

    //     rst   v    ctrl rs rt rd imm    fl      stall vld ctrl imm       rd sc fc
    vec(1'b1, 1'b0, 9'h0, 0, 0, 0, 6'h00, 1'b0, mk(0, 0, 9'h0, 16'h0000, 0, 0, 0));
    vec(1'b0, 1'b1, ADD,  1, 2, 3, 6'h3F, 1'b0, mk(0, 0, 9'h0, 16'h0000, 0, 0, 0));
    vec(1'b0, 1'b1, LW,   4, 2, 0, 6'h05, 1'b0, mk(0, 1, ADD,  16'hFFFF, 3, 0, 0));
    vec(1'b0, 1'b1, ADD,  2, 6, 7, 6'h01, 1'b0, mk(1, 1, LW,   16'h0005, 0, 0, 0));
    vec(1'b0, 1'b1, ADD,  2, 6, 7, 6'h01, 1'b0, mk(0, 0, 9'h0, 16'h0000, 0, 1, 0));
    vec(1'b0, 1'b1, LW,   1, 2, 0, 6'h20, 1'b0, mk(0, 1, ADD,  16'h0001, 7, 1, 0));
    vec(1'b0, 1'b1, LW,   5, 2, 0, 6'h00, 1'b0, mk(0, 1, LW,   16'hFFE0, 0, 1, 0));
    vec(1'b0, 1'b1, J,    2, 2, 0, 6'h03, 1'b0, mk(0, 1, LW,   16'h0000, 0, 1, 0));
    vec(1'b0, 1'b1, ADD,  1, 2, 3, 6'h00, 1'b1, mk(0, 1, J,    16'h0003, 0, 1, 0));
    vec(1'b0, 1'b1, LW,   0, 2, 0, 6'h00, 1'b0, mk(0, 0, 9'h0, 16'h0000, 0, 1, 1));
    vec(1'b0, 1'b1, ADD,  3, 2, 4, 6'h00, 1'b1, mk(0, 1, LW,   16'h0000, 0, 1, 1));
    vec(1'b0, 1'b0, ADD,  1, 1, 1, 6'h00, 1'b0, mk(0, 0, 9'h0, 16'h0000, 0, 1, 2));
    vec(1'b0, 1'b1, LW,   0, 0, 0, 6'h00, 1'b0, mk(0, 0, 9'h0, 16'h0000, 0, 1, 2));
    vec(1'b0, 1'b1, ADD,  0, 1, 2, 6'h00, 1'b0, mk(1, 1, LW,   16'h0000, 0, 1, 2));

    // Twenty load-use hazards; the 4-bit stall counter must pin at 0xF
    for (int i = 0; i < 20; i++) begin
      sat = (2 + i > 15) ? 15 : 2 + i;
      vec(1'b0, 1'b1, LW,  4, 2, 0, 6'h00, 1'b0, mk(0, 0, 9'h0, 16'h0000, 0, 4'(sat), 2));
      vec(1'b0, 1'b1, ADD, 2, 6, 1, 6'h00, 1'b0, mk(1, 1, LW,   16'h0000, 0, 4'(sat), 2));
    end
    vec(1'b0, 1'b1, LW,   4, 2, 0, 6'h00, 1'b0, mk(0, 0, 9'h0, 16'h0000, 0, 15, 2));
    // Reset asserted in a hazard cycle
    vec(1'b1, 1'b1, ADD,  2, 6, 1, 6'h00, 1'b0, mk(1, 1, LW,   16'h0000, 0, 15, 2));
    vec(1'b0, 1'b1, ADD,  2, 6, 1, 6'h00, 1'b0, mk(0, 0, 9'h0, 16'h0000, 0, 0, 0));

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage of the 16-bit RISC core. It captures the control decoder's 9-bit control word and 2-bit ALU op, along with register-file operands, the immediate and register addresses, and presents them to EX one cycle later. It contains the load-use hazard detector: it stalls IF/ID and inserts a bubble. It also squashes the instruction entering EX on a taken branch or jump, and keeps saturating stall and flush event counters.

## Interface
- `REG_ADDR_BITS`, default 3: register address width.
- `REG_SIZE`, default 16: register data width.
- `PC_SIZE`, default 16: program counter width.
- `CNT_W`, default 16: event counter width.
- `clk`, in, 1: clock.
- `rst`, in, 1: reset. One clock; reset is synchronous and active-high.
- `id_valid`, in, 1: the ID stage holds a real instruction.
- `id_pc`, in, PC_SIZE: PC of the ID instruction.
- `id_ctrl`, in, 9: control word from the decoder. Bits {bne, write_enable, mem_to_reg, reg_dst, alu_src, mem_write, mem_read, beq, jump}, [8:0].
- `id_alu_op`, in, 2: ALU op. 00 = R-type, 01 = branch compare, 10 = address add.
- `id_rs`, `id_rt`, `id_rd`, in, REG_ADDR_BITS: register fields.
- `id_rs_data`, `id_rt_data`, in, REG_SIZE: register-file read data.
- `id_imm`, in, 6: raw immediate, instruction bits [5:0].
- `id_funct`, in, 3: function field for the ALU control.
- `flush`, in, 1: taken branch or jump resolved in EX.
- `stall`, out, 1: hold PC and IF/ID this cycle.
- `ex_valid`, out, 1: the EX slot holds a real instruction.
- `ex_ctrl`, out, 9: registered control word.
- `ex_alu_op`, out, 2: registered ALU op.
- `ex_pc`, out, PC_SIZE: registered PC.
- `ex_rs`, `ex_rt`, `ex_rd`, out, REG_ADDR_BITS: registered register fields.
- `ex_rs_data`, `ex_rt_data`, out, REG_SIZE: registered operands.
- `ex_imm`, out, REG_SIZE: sign-extended immediate.
- `ex_funct`, out, 3: registered function field.
- `stall_cnt`, `flush_cnt`, out, CNT_W: saturating event counters.

## Operation
- **Source-use decode (from `id_ctrl`).**
  - `uses_rs` = !jump.
  - `uses_rt` = !jump && !mem_read. LW writes rt, so rt is not a source for LW.
- **Hazard.** `hazard` = id_valid && ex_valid && ex_ctrl[2] (mem_read) && ((uses_rs && id_rs == ex_rt) || (uses_rt && id_rt == ex_rt)). Register 0 is not special.
- `stall` = hazard && !flush. This is combinational from ID inputs and registered EX state.
- **Next EX slot, in priority order:**
  - `flush`: bubble. ex_valid=0 and ex_ctrl=0, so no write, no memory access and no branch. flush_cnt increments.
  - `hazard`: bubble. stall_cnt increments. The ID instruction is retained upstream and re-presented next cycle.
  - `!id_valid`: bubble. No counter change.
  - Otherwise: load all ex_* fields from ID inputs, and set ex_valid=1.
- A bubble forces only ex_valid and ex_ctrl to 0. Data, address and PC fields are don't-care. They are loaded from the inputs so that the datapath mux remains simple.
- **Immediate.** ex_imm = {{(REG_SIZE-6){id_imm[5]}}, id_imm}.
- **Counters.** They saturate at all-ones and do not wrap.

## Timing
- Latency from ID to EX is 1 cycle, and the stage has no internal buffering beyond one slot.
- A load-use hazard produces exactly one stall cycle. After the bubble, ex_ctrl[2]=0, so the re-presented instruction proceeds on the following edge.
- On simultaneous flush and hazard, flush wins: stall=0, bubble inserted, only flush_cnt increments.
- Reset at any point, including mid-stall or mid-flush: on the next edge, all ex_* outputs, stall_cnt and flush_cnt become 0. stall reads 0 in the following cycle because ex_valid=0.
- Reset value of every registered output is 0.

## Structure
- The shared package `risc_pkg` holds:
  - the control-bit index constants CTRL_BNE..CTRL_JUMP (8..0);
  - the ALU_OP encodings (ALUOP_RTYPE=00, ALUOP_BR=01, ALUOP_MEM=10);
  - width constants matching the core defines (REG_ADDR_BITS, REG_SIZE, PC_SIZE).
- One sub-module is natural: `load_use_detect`, the combinational `hazard` equation, reusable by a later forwarding unit. The register slot and counters live in the top.

## Test plan
- **Pass-through.** Reset, then present an ADD (ctrl 0x0A0, alu_op 00, rs=1, rt=2, rd=3, imm=0x3F) -> next cycle ex_valid=1, ex_ctrl=0x0A0, ex_imm=0xFFFF, stall=0.
- **Load-use hazard.** LW to rt=2 (ctrl 0x0D4) in EX, ADD reading rs=2 in ID -> stall=1 for one cycle, bubble (ex_ctrl=0), stall_cnt=1, then ADD enters EX.
- **No false stall.** LW to rt=2 in EX, next instruction LW with rt=2 and rs=5 -> stall=0 (rt is not a source). J in ID -> stall=0.
- **Flush.** flush=1 with a valid ADD in ID -> ex_valid=0, ex_ctrl=0, flush_cnt=1. flush=1 together with a hazard -> stall=0, flush_cnt increments, stall_cnt unchanged.
- **Saturation.** Preload near the limit with CNT_W=4, then apply 20 hazards -> stall_cnt holds 0xF.
- **Reset mid-stall.** Assert rst during a hazard cycle -> next cycle all outputs are 0 and stall=0.
